// File: rtl/arm_cond_pkg.sv
// Shared ARM condition-code constants, flag bit positions and flag-vector type.
package arm_cond_pkg;

  typedef logic [3:0] flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // AL and the 1111 encoding never look at the flags.
  function automatic logic cond_uses_flags(input logic [3:0] cond);
    return (cond != COND_AL) && (cond != COND_NV);
  endfunction

endpackage

// File: rtl/flag_pending_pipe.sv
// Shift register of in-flight flag writers; bit FLAG_LAT-1 is the writer in EX this cycle.
// Flush kills the younger bits [FLAG_LAT-2:0]; the tail writer retires normally.
module flag_pending_pipe #(
  parameter int FLAG_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_i,
  input  logic flush_i,
  output logic tail_o,
  output logic younger_o
);

  logic [FLAG_LAT-1:0] pend_q, pend_d;

  generate
    if (FLAG_LAT == 1) begin : g_single
      always_comb begin
        pend_d = set_i & ~flush_i;
      end
      assign younger_o = 1'b0;
    end else begin : g_multi
      always_comb begin
        pend_d = {(flush_i ? '0 : pend_q[FLAG_LAT-2:0]), set_i & ~flush_i};
      end
      assign younger_o = |pend_q[FLAG_LAT-2:0];
    end
  endgenerate

  assign tail_o = pend_q[FLAG_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/status_flag_unit.sv
// NZCV flag register with ID-stage condition interlock and sticky write-protocol checker.
// Optional STATUS_FLAG_FWD_EN bypasses the EX write onto flags and drops the tail-bit stall.
module status_flag_unit
  import arm_cond_pkg::*;
#(
  parameter int FLAG_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       id_set_flags,
  input  logic       flush,
  input  logic       exe_flags_we,
  input  logic [3:0] exe_flags,
  output logic [3:0] flags,
  output logic       cond_stall,
  output logic       issue,
  output logic       flag_err
);

  flags_t flags_q, flags_d;
  logic   flag_err_q, flag_err_d;
  logic   pend_tail, pend_younger;
  logic   stall_src;

  flag_pending_pipe #(
    .FLAG_LAT (FLAG_LAT)
  ) u_pend (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_i     (issue & id_set_flags),
    .flush_i   (flush),
    .tail_o    (pend_tail),
    .younger_o (pend_younger)
  );

  always_comb begin
    flags_d    = exe_flags_we ? flags_t'(exe_flags) : flags_q;
    flag_err_d = flag_err_q | (exe_flags_we ^ pend_tail);
  end

`ifdef STATUS_FLAG_FWD_EN
  // The tail writer's result is visible through the bypass in the same cycle.
  assign stall_src = pend_younger;
  assign flags     = flags_d;
`else
  assign stall_src = pend_younger | pend_tail;
  assign flags     = flags_q;
`endif

  assign cond_stall = id_valid & cond_uses_flags(id_cond) & stall_src;
  assign issue      = id_valid & ~cond_stall & ~flush;
  assign flag_err   = flag_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= '0;
      flag_err_q <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      flag_err_q <= flag_err_d;
    end
  end

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench for status_flag_unit at FLAG_LAT=2; expectations follow STATUS_FLAG_FWD_EN.
module tb_status_flag_unit;
  import arm_cond_pkg::*;

`ifdef STATUS_FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_cond;
  logic       id_set_flags;
  logic       flush;
  logic       exe_flags_we;
  logic [3:0] exe_flags;
  logic [3:0] flags;
  logic       cond_stall;
  logic       issue;
  logic       flag_err;

  int n_chk = 0;
  int n_bad = 0;

  status_flag_unit #(.FLAG_LAT(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_cond      (id_cond),
    .id_set_flags (id_set_flags),
    .flush        (flush),
    .exe_flags_we (exe_flags_we),
    .exe_flags    (exe_flags),
    .flags        (flags),
    .cond_stall   (cond_stall),
    .issue        (issue),
    .flag_err     (flag_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b want=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    id_valid     = 1'b0;
    id_cond      = COND_AL;
    id_set_flags = 1'b0;
    flush        = 1'b0;
    exe_flags_we = 1'b0;
    exe_flags    = 4'b0000;
  endtask

  task automatic id(input logic [3:0] c, input logic s);
    id_valid     = 1'b1;
    id_cond      = c;
    id_set_flags = s;
  endtask

  task automatic ex(input logic [3:0] f);
    exe_flags_we = 1'b1;
    exe_flags    = f;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    chk("rst_flags", flags, 4'b0000);
    chk("rst_stall", {3'b000, cond_stall}, 4'b0000);
    chk("rst_err",   {3'b000, flag_err}, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Hazard: S-instruction then BEQ.
    idle(); id(COND_AL, 1'b1); settle();
    chk("haz_s_issue", {3'b000, issue}, 4'b0001);
    tick();
    idle(); id(COND_EQ, 1'b0); settle();
    chk("haz_c1_stall", {3'b000, cond_stall}, 4'b0001);
    chk("haz_c1_issue", {3'b000, issue}, 4'b0000);
    tick();
    idle(); id(COND_EQ, 1'b0); ex(4'b0100); settle();
    chk("haz_c2_stall", {3'b000, cond_stall}, FWD ? 4'b0000 : 4'b0001);
    chk("haz_c2_issue", {3'b000, issue}, FWD ? 4'b0001 : 4'b0000);
    if (FWD) chk("haz_c2_fwd_flags", flags, 4'b0100);
    tick();
    idle(); id(COND_EQ, 1'b0); settle();
    chk("haz_c3_stall", {3'b000, cond_stall}, 4'b0000);
    chk("haz_c3_issue", {3'b000, issue}, 4'b0001);
    chk("haz_c3_flags", flags, 4'b0100);
    chk("haz_err", {3'b000, flag_err}, 4'b0000);
    tick();

    // AL behind an S-instruction never stalls.
    idle(); id(COND_AL, 1'b1); settle();
    chk("al_c0_issue", {3'b000, issue}, 4'b0001);
    tick();
    idle(); id(COND_AL, 1'b0); settle();
    chk("al_c1_stall", {3'b000, cond_stall}, 4'b0000);
    chk("al_c1_issue", {3'b000, issue}, 4'b0001);
    tick();
    idle(); id(COND_NV, 1'b0); ex(4'b0010); settle();
    chk("al_c2_stall", {3'b000, cond_stall}, 4'b0000);
    chk("al_c2_issue", {3'b000, issue}, 4'b0001);
    tick();
    idle(); settle();
    chk("al_flags", flags, 4'b0010);
    chk("al_err", {3'b000, flag_err}, 4'b0000);
    tick();

    // Back-to-back flag writers.
    idle(); id(COND_AL, 1'b1); settle();
    chk("b2b_i0", {3'b000, issue}, 4'b0001);
    tick();
    idle(); id(COND_AL, 1'b1); settle();
    chk("b2b_i1", {3'b000, issue}, 4'b0001);
    tick();
    idle(); ex(4'b1000); settle();
    tick();
    idle(); ex(4'b0011); settle();
    chk("b2b_flags_a", flags, FWD ? 4'b0011 : 4'b1000);
    tick();
    idle(); settle();
    chk("b2b_flags_b", flags, 4'b0011);
    chk("b2b_err", {3'b000, flag_err}, 4'b0000);
    tick();

    // Issue of a setter in the same cycle as a flag write.
    idle(); id(COND_AL, 1'b1); settle();
    tick();
    idle(); settle();
    tick();
    idle(); id(COND_AL, 1'b1); ex(4'b1001); settle();
    chk("sim_issue", {3'b000, issue}, 4'b0001);
    tick();
    idle(); id(COND_GT, 1'b0); settle();
    chk("sim_flags", flags, 4'b1001);
    chk("sim_stall", {3'b000, cond_stall}, 4'b0001);
    chk("sim_hold", {3'b000, issue}, 4'b0000);
    tick();
    idle(); ex(4'b0001); settle();
    tick();
    idle(); settle();
    chk("sim_flags2", flags, 4'b0001);
    chk("sim_err", {3'b000, flag_err}, 4'b0000);
    tick();

    // Flush kills the writer in bit0; a later orphan write is an error.
    idle(); id(COND_AL, 1'b1); settle();
    tick();
    idle(); id(COND_AL, 1'b1); flush = 1'b1; settle();
    chk("fl_issue_blocked", {3'b000, issue}, 4'b0000);
    tick();
    idle(); id(COND_EQ, 1'b0); settle();
    chk("fl_stall_cleared", {3'b000, cond_stall}, 4'b0000);
    chk("fl_issue", {3'b000, issue}, 4'b0001);
    tick();
    idle(); ex(4'b1111); settle();
    chk("fl_err_pre", {3'b000, flag_err}, 4'b0000);
    tick();
    idle(); settle();
    chk("fl_err_set", {3'b000, flag_err}, 4'b0001);
    chk("fl_flags", flags, 4'b1111);
    tick();
    tick();
    chk("fl_err_sticky", {3'b000, flag_err}, 4'b0001);

    // Asynchronous reset mid-operation with a writer in flight.
    idle(); id(COND_AL, 1'b1); settle();
    tick();
    idle(); id(COND_EQ, 1'b0); settle();
    chk("ar_pre_stall", {3'b000, cond_stall}, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("ar_flags", flags, 4'b0000);
    chk("ar_stall", {3'b000, cond_stall}, 4'b0000);
    chk("ar_err", {3'b000, flag_err}, 4'b0000);
    tick();
    rst_n = 1'b1;
    settle();
    tick();
    idle(); id(COND_EQ, 1'b0); settle();
    chk("ar_post_stall", {3'b000, cond_stall}, 4'b0000);
    chk("ar_post_issue", {3'b000, issue}, 4'b0001);
    chk("ar_post_err", {3'b000, flag_err}, 4'b0000);
    tick();
    idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
